// File: rtl/proc_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// proc_seq_ctrl_if
// Bundles every non-clock/reset signal of the processor sequencer.
//
// Protocol: start and step are single-cycle pulses. They are sampled on the
// rising edge only while the sequencer sits in IDLE (start and step) or HALT
// (start only). A pulse seen in any other state is dropped, not queued.
// ins is the synchronous instruction-memory read data for imem_addr one
// cycle earlier. nextpc and wra come from the execute stage and must be
// stable from EXEC until the end of WB.
//
// Modports
//   master : host / datapath side (drives start, step_en, step, ins,
//            nextpc, wra; observes everything else)
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface proc_seq_ctrl_if #(
   parameter int IMEM_AW = 8
);
   logic               start;
   logic               step_en;
   logic               step;
   logic [31:0]        ins;
   logic [31:0]        nextpc;
   logic [4:0]         wra;
   logic [31:0]        pc;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        ir;
   logic               dm_wr_gate;
   logic               rf_we;
   logic [4:0]         rf_wa;
   logic [2:0]         state;
   logic               halted;
   logic [31:0]        retired;

   modport master (
      output start, step_en, step, ins, nextpc, wra,
      input  pc, imem_addr, ir, dm_wr_gate, rf_we, rf_wa, state, halted,
             retired
   );

   modport slave (
      input  start, step_en, step, ins, nextpc, wra,
      output pc, imem_addr, ir, dm_wr_gate, rf_we, rf_wa, state, halted,
             retired
   );
endinterface

// File: rtl/proc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// proc_seq_ctrl
// Multi-cycle sequencer for the single-issue processor. Steps every
// instruction through FETCH, DECODE, EXEC, optional MEM and WB; drives the
// instruction-memory address and the instruction register; gates data-memory
// and register-file writes; commits the execute-stage next PC in WB.
// Supports free-run, single-step (step_en=1) and HALT for host bring-up.
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : proc_seq_ctrl_if.slave (start, step_en, step, ins, nextpc, wra
//            in; pc, imem_addr, ir, dm_wr_gate, rf_we, rf_wa, state, halted,
//            retired out)
//
// Optional feature: define PROC_SEQ_CTRL_PERF_EN to enable the retired
// instruction counter (bus.retired) and an internal cycle counter (cycles)
// that counts every cycle spent outside IDLE/HALT. Without it retired is 0.
//
// dm_wr_gate, rf_we and halted are registered from the next-state decode, so
// no output has a combinational path from ins.
// ---------------------------------------------------------------------------
module proc_seq_ctrl #(
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter int          IMEM_AW  = 8,
   parameter logic [5:0]  HALT_OP  = 6'd63
) (
   input logic            clk,
   input logic            rst_n,
   proc_seq_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q;
   logic [31:0] ir_q;
   logic        dm_wr_gate_q, dm_wr_gate_d;
   logic        rf_we_q, rf_we_d;
   logic        halted_q, halted_d;
   logic [5:0]  op;

   assign op = ir_q[31:26];

   // Loads (16,18,20) and stores (24,26,28) take the MEM detour.
   function automatic logic is_mem_op(input logic [5:0] o);
      return (o == 6'd16) || (o == 6'd18) || (o == 6'd20) ||
             (o == 6'd24) || (o == 6'd26) || (o == 6'd28);
   endfunction

   function automatic logic is_store(input logic [5:0] o);
      return (o == 6'd24) || (o == 6'd26) || (o == 6'd28);
   endfunction

   // Opcodes that produce a register-file result.
   function automatic logic writes_rf(input logic [5:0] o);
      return (o == 6'd0)  || (o == 6'd1)  || (o == 6'd3)  || (o == 6'd4)  ||
             (o == 6'd5)  || (o == 6'd6)  || (o == 6'd16) || (o == 6'd18) ||
             (o == 6'd20) || (o == 6'd41);
   endfunction

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next state / next outputs ----------------
   always_comb begin
      state_d      = state_q;
      dm_wr_gate_d = 1'b0;
      rf_we_d      = 1'b0;
      halted_d     = 1'b0;
      case (state_q)
         // In single-step mode only step counts, so step wins over start.
         S_IDLE:   if (bus.step_en ? bus.step : bus.start) state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: state_d = (bus.ins[31:26] == HALT_OP) ? S_HALT : S_EXEC;
         S_EXEC:   state_d = is_mem_op(op) ? S_MEM : S_WB;
         S_MEM:    state_d = S_WB;
         S_WB:     state_d = bus.step_en ? S_IDLE : S_FETCH;
         S_HALT:   if (bus.start) state_d = S_FETCH;
         default:  state_d = S_IDLE;
      endcase
      // Qualifiers are computed for the state being entered and registered,
      // so they are high exactly during that state.
      dm_wr_gate_d = (state_d == S_MEM) && is_store(op);
      rf_we_d      = (state_d == S_WB) && writes_rf(op) && (bus.wra != 5'd0);
      halted_d     = (state_d == S_HALT);
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         ir_q         <= 32'd0;
         dm_wr_gate_q <= 1'b0;
         rf_we_q      <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         dm_wr_gate_q <= dm_wr_gate_d;
         rf_we_q      <= rf_we_d;
         halted_q     <= halted_d;
         if (state_q == S_DECODE) ir_q <= bus.ins;
         if (state_q == S_WB) begin
            pc_q <= bus.nextpc;
         end else if ((state_q == S_HALT) && bus.start) begin
            pc_q <= RESET_PC;
         end
      end
   end

`ifdef PROC_SEQ_CTRL_PERF_EN
   logic [31:0] retired_q;
   logic [31:0] cycles;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_q <= 32'd0;
         cycles    <= 32'd0;
      end else begin
         if (state_q == S_WB) retired_q <= retired_q + 32'd1;
         if ((state_q != S_IDLE) && (state_q != S_HALT)) cycles <= cycles + 32'd1;
      end
   end

   assign bus.retired = retired_q;
`else
   assign bus.retired = 32'd0;
`endif

   assign bus.pc         = pc_q;
   assign bus.imem_addr  = pc_q[IMEM_AW-1:0];
   assign bus.ir         = ir_q;
   assign bus.dm_wr_gate = dm_wr_gate_q;
   assign bus.rf_we      = rf_we_q;
   assign bus.rf_wa      = bus.wra;
   assign bus.state      = state_q;
   assign bus.halted     = halted_q;

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_proc_seq_ctrl
// Directed bench for proc_seq_ctrl. Provides a 1-cycle synchronous
// instruction memory, an execute-stage stand-in (nextpc = pc+1 unless
// overridden, wra = ir[20:16]) and walks reset, free-run, store, load,
// branch, HALT and single-step scenarios with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_proc_seq_ctrl;

   logic        clk;
   logic        rst_n;
   int          n_cmp;
   int          n_err;
   int          rf_wr_cnt;
   int          wr_base;
   logic [31:0] imem [0:255];
   logic        npc_ovr_en;
   logic [31:0] npc_ovr;

   proc_seq_ctrl_if #(.IMEM_AW(8)) bus ();

   proc_seq_ctrl #(
      .RESET_PC (32'd0),
      .IMEM_AW  (8),
      .HALT_OP  (6'd63)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- memory / execute-stage models ----------------
   always @(posedge clk) bus.ins <= imem[bus.imem_addr];
   assign bus.nextpc = npc_ovr_en ? npc_ovr : (bus.pc + 32'd1);
   assign bus.wra    = bus.ir[20:16];

   // Register-file write monitor, sampled mid-cycle.
   always @(negedge clk) if (bus.rf_we === 1'b1) rf_wr_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic pulse_step();
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      rf_wr_cnt   = 0;
      npc_ovr_en  = 1'b0;
      npc_ovr     = 32'd0;
      bus.start   = 1'b0;
      bus.step    = 1'b0;
      bus.step_en = 1'b0;
      for (int i = 0; i < 256; i++) imem[i] = 32'd0;
      imem[0] = 32'h0403_0005;   // ADDI rt=3, imm=5
      imem[1] = 32'hFC00_0000;   // HALT

      // ---------------- reset ----------------
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_state", {29'd0, bus.state}, 32'd0);
      chk("rst_pc", bus.pc, 32'd0);
      chk("rst_ir", bus.ir, 32'd0);
      chk("rst_halted", {31'd0, bus.halted}, 32'd0);
      chk("rst_retired", bus.retired, 32'd0);
      rst_n = 1'b1;
      tick();

      // ---------------- reset mid-EXEC aborts the instruction ----------------
      pulse_start();                       // FETCH
      tick();                              // DECODE
      tick();                              // EXEC
      chk("midexec_state", {29'd0, bus.state}, 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_state", {29'd0, bus.state}, 32'd0);
      chk("async_pc", bus.pc, 32'd0);
      chk("async_rf_we", {31'd0, bus.rf_we}, 32'd0);
      chk("async_dm", {31'd0, bus.dm_wr_gate}, 32'd0);
      tick();
      rst_n = 1'b1;
      wr_base = rf_wr_cnt;
      for (int i = 0; i < 6; i++) tick();
      chk("postrst_no_write", rf_wr_cnt - wr_base, 32'd0);
      chk("postrst_idle", {29'd0, bus.state}, 32'd0);

      // ---------------- free run ADDI then HALT ----------------
      pulse_start();
      chk("addi_fetch", {29'd0, bus.state}, 32'd1);
      chk("addi_imem_addr", {24'd0, bus.imem_addr}, 32'd0);
      tick();
      chk("addi_decode", {29'd0, bus.state}, 32'd2);
      tick();
      chk("addi_exec", {29'd0, bus.state}, 32'd3);
      chk("addi_ir", bus.ir, 32'h0403_0005);
      tick();
      chk("addi_wb", {29'd0, bus.state}, 32'd5);
      chk("addi_rf_we", {31'd0, bus.rf_we}, 32'd1);
      chk("addi_rf_wa", {27'd0, bus.rf_wa}, 32'd3);
      tick();
      chk("halt_fetch_pc", bus.pc, 32'd1);
      chk("halt_fetch_rf_we", {31'd0, bus.rf_we}, 32'd0);
      tick();
      tick();
      chk("halt_state", {29'd0, bus.state}, 32'd6);
      chk("halt_halted", {31'd0, bus.halted}, 32'd1);
      chk("halt_pc", bus.pc, 32'd1);
      tick();
      chk("halt_hold_pc", bus.pc, 32'd1);
      pulse_step();
      chk("halt_step_ignored", {29'd0, bus.state}, 32'd6);

      // ---------------- branch / store / load / op0 wra=0 ----------------
      imem[0]    = 32'h1000_0000;   // BEQ (op4), rt=0
      imem[2]    = 32'h6009_0000;   // SW  (op24), rt=9
      imem[3]    = 32'h4007_0000;   // LW  (op16), rt=7
      imem[4]    = 32'h0000_1820;   // R-type op0, rt=0
      imem[8'h20] = 32'hFC00_0000;  // HALT
      npc_ovr_en = 1'b1;
      npc_ovr    = 32'd2;
      pulse_start();                       // restart from HALT
      chk("restart_pc", bus.pc, 32'd0);
      chk("restart_halted", {31'd0, bus.halted}, 32'd0);
      tick();
      tick();
      tick();
      chk("beq_wb", {29'd0, bus.state}, 32'd5);
      chk("beq_rf_we", {31'd0, bus.rf_we}, 32'd0);
      tick();
      npc_ovr_en = 1'b0;
      chk("sw_fetch_pc", bus.pc, 32'd2);
      tick();
      tick();
      chk("sw_exec_dm", {31'd0, bus.dm_wr_gate}, 32'd0);
      tick();
      chk("sw_mem_state", {29'd0, bus.state}, 32'd4);
      chk("sw_mem_dm", {31'd0, bus.dm_wr_gate}, 32'd1);
      chk("sw_mem_rf_we", {31'd0, bus.rf_we}, 32'd0);
      tick();
      chk("sw_wb_state", {29'd0, bus.state}, 32'd5);
      chk("sw_wb_dm", {31'd0, bus.dm_wr_gate}, 32'd0);
      chk("sw_wb_rf_we", {31'd0, bus.rf_we}, 32'd0);
      tick();
      chk("sw_pc_after5", bus.pc, 32'd3);
      chk("lw_fetch", {29'd0, bus.state}, 32'd1);
      tick();
      chk("lw_decode", {29'd0, bus.state}, 32'd2);
      tick();
      chk("lw_exec", {29'd0, bus.state}, 32'd3);
      tick();
      chk("lw_mem", {29'd0, bus.state}, 32'd4);
      chk("lw_mem_dm", {31'd0, bus.dm_wr_gate}, 32'd0);
      tick();
      chk("lw_wb", {29'd0, bus.state}, 32'd5);
      chk("lw_rf_we", {31'd0, bus.rf_we}, 32'd1);
      chk("lw_rf_wa", {27'd0, bus.rf_wa}, 32'd7);
      tick();
      chk("op0_fetch_pc", bus.pc, 32'd4);
      npc_ovr_en = 1'b1;
      npc_ovr    = 32'h20;
      wr_base    = rf_wr_cnt;
      tick();
      tick();
      tick();
      chk("op0_wb", {29'd0, bus.state}, 32'd5);
      chk("op0_rf_we", {31'd0, bus.rf_we}, 32'd0);
      tick();
      npc_ovr_en = 1'b0;
      chk("branch_pc", bus.pc, 32'h20);
      chk("op0_no_write", rf_wr_cnt - wr_base, 32'd0);
      tick();
      tick();
      chk("halt2_halted", {31'd0, bus.halted}, 32'd1);
      chk("halt2_pc", bus.pc, 32'h20);

      // ---------------- single-step ----------------
      imem[0] = 32'h0403_0001;   // ADDI rt=3
      imem[1] = 32'h0404_0001;   // ADDI rt=4
      imem[2] = 32'h0405_0001;   // ADDI rt=5
      imem[3] = 32'hFC00_0000;   // HALT
      #2;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.step_en = 1'b1;
      tick();
      wr_base = rf_wr_cnt;
      pulse_start();
      chk("step_mode_start_ignored", {29'd0, bus.state}, 32'd0);
      pulse_step();
      chk("step1_fetch", {29'd0, bus.state}, 32'd1);
      tick();
      bus.step = 1'b1;                     // arrives in DECODE: dropped
      tick();
      bus.step = 1'b0;
      tick();
      chk("step1_wb_rf_we", {31'd0, bus.rf_we}, 32'd1);
      chk("step1_wb_rf_wa", {27'd0, bus.rf_wa}, 32'd3);
      tick();
      chk("step1_idle", {29'd0, bus.state}, 32'd0);
      chk("step1_pc", bus.pc, 32'd1);
      for (int i = 0; i < 6; i++) tick();
      chk("step1_not_queued", {29'd0, bus.state}, 32'd0);
      pulse_step();
      for (int i = 0; i < 9; i++) tick();
      chk("step2_idle", {29'd0, bus.state}, 32'd0);
      chk("step2_pc", bus.pc, 32'd2);
      pulse_step();
      for (int i = 0; i < 9; i++) tick();
      chk("step3_idle", {29'd0, bus.state}, 32'd0);
      chk("step3_pc", bus.pc, 32'd3);
      chk("step_writes", rf_wr_cnt - wr_base, 32'd3);
`ifdef PROC_SEQ_CTRL_PERF_EN
      chk("retired", bus.retired, 32'd3);
      chk("cycles", dut.cycles, 32'd12);
`else
      chk("retired_tied", bus.retired, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
